hci_core_ooo_starvation_ctrl: RTL and testbench

Arbitration controller for the HCI dynamic out-of-order N-to-1 multiplexer. It observes per-channel request, grant and response handshakes, limits outstanding transactions per channel with a request mask, and drives the mux's `priority_force_i`/`priority_i` inputs. When a channel has waited too long it forces that channel to top priority until it is served. It sits next to the OoO mux in the initiator-side cluster interconnect and adds no datapath, only control.

---
 rtl/hci_core_ooo_starvation_ctrl.sv | 146 ++++++++++++++
 tb/tb_hci_core_ooo_starvation_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hci_core_ooo_starvation_ctrl.sv
// Arbitration controller beside the HCI out-of-order N-to-1 mux: caps in-flight
// transactions per channel and forces a waiting channel to top priority once it starves.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | mux runs its own arbitration, priority_force_o = 0
// S_BOOST | r_boost_ch forced to rank 0 until granted, dropped or disabled
module hci_core_ooo_starvation_ctrl #(
  parameter int unsigned NB_CHAN         = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_THR      = 16,
  localparam int unsigned CHW            = $clog2(NB_CHAN),
  localparam int unsigned OW             = $clog2(MAX_OUTSTANDING + 1),
  localparam int unsigned SW             = $clog2(STARVE_THR + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   enable_i,
  input  logic [NB_CHAN-1:0]     in_req_i,
  input  logic [NB_CHAN-1:0]     in_gnt_i,
  input  logic [NB_CHAN-1:0]     in_r_valid_i,
  input  logic [NB_CHAN-1:0]     in_r_ready_i,
  output logic [NB_CHAN-1:0]     req_mask_o,
  output logic                   priority_force_o,
  output logic [NB_CHAN*CHW-1:0] priority_o,
  output logic [NB_CHAN*OW-1:0]  outstanding_o,
  output logic [NB_CHAN-1:0]     starved_o,
  output logic                   err_underflow_o,
  output logic                   busy_o
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BOOST = 1'b1;

  logic [OW-1:0]    r_cnt  [NB_CHAN];
  logic [SW-1:0]    r_wait [NB_CHAN];
  logic [0:0]       r_state;
  logic [CHW-1:0]   r_boost_ch;
  logic             r_err;

  logic             w_rst;
  logic [NB_CHAN-1:0] w_mask;
  logic [NB_CHAN-1:0] w_req_hs;
  logic [NB_CHAN-1:0] w_rsp_hs;
  logic [NB_CHAN-1:0] w_starved;
  logic [CHW-1:0]   w_starve_idx;
  logic             w_boost_exit;
  logic [CHW:0]     w_sum;

  assign w_rst = rst_i | clear_i;

  always_comb begin
    w_mask    = '0;
    w_starved = '0;
    for (int i = 0; i < NB_CHAN; i++) begin
      w_mask[i]    = (r_cnt[i] < OW'(MAX_OUTSTANDING));
      w_starved[i] = (r_wait[i] == SW'(STARVE_THR));
    end
  end

  assign w_req_hs = in_req_i & w_mask & in_gnt_i;
  assign w_rsp_hs = in_r_valid_i & in_r_ready_i;

  // Descending scan so the lowest starved index is the one left standing.
  always_comb begin
    w_starve_idx = '0;
    for (int i = int'(NB_CHAN) - 1; i >= 0; i--) begin
      if (w_starved[i]) w_starve_idx = CHW'(i);
    end
  end

  assign w_boost_exit = in_gnt_i[r_boost_ch]
                      | ~(in_req_i[r_boost_ch] & w_mask[r_boost_ch])
                      | ~enable_i;

  always_ff @(posedge clk_i) begin
    if (w_rst) begin
      for (int i = 0; i < NB_CHAN; i++) begin
        r_cnt[i]  <= '0;
        r_wait[i] <= '0;
      end
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < NB_CHAN; i++) begin
        if (w_req_hs[i] && !w_rsp_hs[i]) begin
          r_cnt[i] <= r_cnt[i] + OW'(1);
        end else if (!w_req_hs[i] && w_rsp_hs[i]) begin
          if (r_cnt[i] == '0) r_err <= 1'b1;
          else                r_cnt[i] <= r_cnt[i] - OW'(1);
        end

        if (in_gnt_i[i] || !(in_req_i[i] && w_mask[i])) begin
          r_wait[i] <= '0;
        end else if (r_wait[i] != SW'(STARVE_THR)) begin
          r_wait[i] <= r_wait[i] + SW'(1);
        end
      end
    end
  end

  // boost channel is only loaded on IDLE->BOOST, so priority_o never moves mid-boost
  always_ff @(posedge clk_i) begin
    if (w_rst) begin
      r_state    <= S_IDLE;
      r_boost_ch <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable_i && |w_starved) begin
            r_state    <= S_BOOST;
            r_boost_ch <= w_starve_idx;
          end
        end
        S_BOOST: begin
          if (w_boost_exit) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    priority_o = '0;
    w_sum      = '0;
    for (int k = 0; k < NB_CHAN; k++) begin
      w_sum = {1'b0, r_boost_ch} + (CHW+1)'(k);
      if (w_sum >= (CHW+1)'(NB_CHAN)) w_sum = w_sum - (CHW+1)'(NB_CHAN);
      priority_o[k*CHW +: CHW] = w_sum[CHW-1:0];
    end
  end

  always_comb begin
    outstanding_o = '0;
    for (int i = 0; i < NB_CHAN; i++) begin
      outstanding_o[i*OW +: OW] = r_cnt[i];
    end
  end

  assign req_mask_o       = w_mask;
  assign starved_o        = w_starved;
  assign priority_force_o = (r_state == S_BOOST);
  assign err_underflow_o  = r_err;
  assign busy_o           = |outstanding_o;

endmodule

// File: tb/tb_hci_core_ooo_starvation_ctrl.sv
// Scoreboard bench for the starvation controller with 4 channels, 2 outstanding, threshold 4.
module tb_hci_core_ooo_starvation_ctrl;

  localparam int unsigned NB_CHAN = 4;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       clear_i = 1'b0;
  logic       enable_i = 1'b0;
  logic [3:0] in_req_i = '0;
  logic [3:0] in_gnt_i = '0;
  logic [3:0] in_r_valid_i = '0;
  logic [3:0] in_r_ready_i = '0;
  logic [3:0] req_mask_o;
  logic       priority_force_o;
  logic [7:0] priority_o;
  logic [7:0] outstanding_o;
  logic [3:0] starved_o;
  logic       err_underflow_o;
  logic       busy_o;

  hci_core_ooo_starvation_ctrl #(
    .NB_CHAN(NB_CHAN), .MAX_OUTSTANDING(2), .STARVE_THR(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .enable_i(enable_i),
    .in_req_i(in_req_i), .in_gnt_i(in_gnt_i),
    .in_r_valid_i(in_r_valid_i), .in_r_ready_i(in_r_ready_i),
    .req_mask_o(req_mask_o), .priority_force_o(priority_force_o),
    .priority_o(priority_o), .outstanding_o(outstanding_o),
    .starved_o(starved_o), .err_underflow_o(err_underflow_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // snapshot layout: {mask[4], force, prio[8], outstanding[8], starved[4], err, busy}
  logic [26:0] act;
  assign act = {req_mask_o, priority_force_o, priority_o, outstanding_o,
                starved_o, err_underflow_o, busy_o};

  typedef struct {
    logic [2:0]  ctl;
    logic [3:0]  req, gnt, rv, rr;
    logic [26:0] e;
  } row_t;

  logic [26:0] sb[$];
  int n_total = 0;
  int n_pass  = 0;

  // priority_o encodings used below: boost 0 -> E4, 1 -> 39, 2 -> 4E, 3 -> 93
  function automatic row_t mk(input logic [2:0] ctl,
                              input logic [3:0] req, gnt, rv, rr,
                              input logic [3:0] m, input logic f, input logic [7:0] p,
                              input logic [7:0] o, input logic [3:0] s,
                              input logic er, input logic bz);
    row_t r;
    r.ctl = ctl; r.req = req; r.gnt = gnt; r.rv = rv; r.rr = rr;
    r.e   = {m, f, p, o, s, er, bz};
    return r;
  endfunction

  // Drive one cycle of stimulus, record what must be visible after the edge.
  task automatic apply(input row_t r);
    {rst_i, clear_i, enable_i} = r.ctl;
    in_req_i = r.req; in_gnt_i = r.gnt; in_r_valid_i = r.rv; in_r_ready_i = r.rr;
    sb.push_back(r.e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    logic [26:0] e;
    rows.push_back(mk(3'b100, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 8'hE4, 8'h00, 4'h0, 1'b0, 1'b0));
    for (int i = 0; i < 20; i++)
      rows.push_back(mk(3'b000, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 8'hE4, 8'h00, 4'h0, 1'b0, 1'b0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sb.pop_front();
      n_total++;
      if (act !== e) $display("FAIL reset row %0d: got %h expected %h", i, act, e);
      else n_pass++;
    end
  endtask

  task automatic test_outstanding();
    row_t rows[$];
    logic [26:0] e;
    rows.push_back(mk(3'b001, 4'h2, 4'h2, 4'h0, 4'h0, 4'hF, 1'b0, 8'hE4, 8'h04, 4'h0, 1'b0, 1'b1));
    rows.push_back(mk(3'b001, 4'h2, 4'h2, 4'h0, 4'h0, 4'hD, 1'b0, 8'hE4, 8'h08, 4'h0, 1'b0, 1'b1));
    rows.push_back(mk(3'b001, 4'h2, 4'h2, 4'h0, 4'h0, 4'hD, 1'b0, 8'hE4, 8'h08, 4'h0, 1'b0, 1'b1));
    rows.push_back(mk(3'b001, 4'h2, 4'h0, 4'h0, 4'h0, 4'hD, 1'b0, 8'hE4, 8'h08, 4'h0, 1'b0, 1'b1));
    rows.push_back(mk(3'b001, 4'h0, 4'h0, 4'h2, 4'h0, 4'hD, 1'b0, 8'hE4, 8'h08, 4'h0, 1'b0, 1'b1));
    rows.push_back(mk(3'b001, 4'h0, 4'h0, 4'h2, 4'h2, 4'hF, 1'b0, 8'hE4, 8'h04, 4'h0, 1'b0, 1'b1));
    rows.push_back(mk(3'b001, 4'h0, 4'h0, 4'h2, 4'h2, 4'hF, 1'b0, 8'hE4, 8'h00, 4'h0, 1'b0, 1'b0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sb.pop_front();
      n_total++;
      if (act !== e) $display("FAIL outstanding row %0d: got %h expected %h", i, act, e);
      else n_pass++;
    end
  endtask

  task automatic test_starve();
    row_t rows[$];
    logic [26:0] e;
    for (int i = 0; i < 3; i++)
      rows.push_back(mk(3'b001, 4'h4, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 8'hE4, 8'h00, 4'h0, 1'b0, 1'b0));
    rows.push_back(mk(3'b001, 4'h4, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 8'hE4, 8'h00, 4'h4, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++)
      rows.push_back(mk(3'b001, 4'h4, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1, 8'h4E, 8'h00, 4'h4, 1'b0, 1'b0));
    rows.push_back(mk(3'b001, 4'h4, 4'h4, 4'h0, 4'h0, 4'hF, 1'b0, 8'h4E, 8'h10, 4'h0, 1'b0, 1'b1));
    rows.push_back(mk(3'b001, 4'h0, 4'h0, 4'h4, 4'h4, 4'hF, 1'b0, 8'h4E, 8'h00, 4'h0, 1'b0, 1'b0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sb.pop_front();
      n_total++;
      if (act !== e) $display("FAIL starve row %0d: got %h expected %h", i, act, e);
      else n_pass++;
    end
  endtask

  task automatic test_multi_starve();
    row_t rows[$];
    logic [26:0] e;
    for (int i = 0; i < 3; i++)
      rows.push_back(mk(3'b001, 4'h9, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 8'h4E, 8'h00, 4'h0, 1'b0, 1'b0));
    rows.push_back(mk(3'b001, 4'h9, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 8'h4E, 8'h00, 4'h9, 1'b0, 1'b0));
    rows.push_back(mk(3'b001, 4'h9, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1, 8'hE4, 8'h00, 4'h9, 1'b0, 1'b0));
    rows.push_back(mk(3'b001, 4'h9, 4'h1, 4'h0, 4'h0, 4'hF, 1'b0, 8'hE4, 8'h01, 4'h8, 1'b0, 1'b1));
    rows.push_back(mk(3'b001, 4'h8, 4'h0, 4'h1, 4'h1, 4'hF, 1'b1, 8'h93, 8'h00, 4'h8, 1'b0, 1'b0));
    rows.push_back(mk(3'b001, 4'h8, 4'h8, 4'h0, 4'h0, 4'hF, 1'b0, 8'h93, 8'h40, 4'h0, 1'b0, 1'b1));
    rows.push_back(mk(3'b001, 4'h0, 4'h0, 4'h8, 4'h8, 4'hF, 1'b0, 8'h93, 8'h00, 4'h0, 1'b0, 1'b0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sb.pop_front();
      n_total++;
      if (act !== e) $display("FAIL multi_starve row %0d: got %h expected %h", i, act, e);
      else n_pass++;
    end
  endtask

  task automatic test_enable_off();
    row_t rows[$];
    logic [26:0] e;
    for (int i = 0; i < 3; i++)
      rows.push_back(mk(3'b000, 4'h2, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 8'h93, 8'h00, 4'h0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++)
      rows.push_back(mk(3'b000, 4'h2, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 8'h93, 8'h00, 4'h2, 1'b0, 1'b0));
    rows.push_back(mk(3'b000, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 8'h93, 8'h00, 4'h0, 1'b0, 1'b0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sb.pop_front();
      n_total++;
      if (act !== e) $display("FAIL enable_off row %0d: got %h expected %h", i, act, e);
      else n_pass++;
    end
  endtask

  task automatic test_underflow();
    row_t rows[$];
    logic [26:0] e;
    rows.push_back(mk(3'b001, 4'h0, 4'h0, 4'h1, 4'h1, 4'hF, 1'b0, 8'h93, 8'h00, 4'h0, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++)
      rows.push_back(mk(3'b001, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 8'h93, 8'h00, 4'h0, 1'b1, 1'b0));
    rows.push_back(mk(3'b011, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 8'hE4, 8'h00, 4'h0, 1'b0, 1'b0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sb.pop_front();
      n_total++;
      if (act !== e) $display("FAIL underflow row %0d: got %h expected %h", i, act, e);
      else n_pass++;
    end
  endtask

  task automatic test_rst_boost_and_simul();
    row_t rows[$];
    logic [26:0] e;
    for (int i = 0; i < 3; i++)
      rows.push_back(mk(3'b001, 4'h2, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 8'hE4, 8'h00, 4'h0, 1'b0, 1'b0));
    rows.push_back(mk(3'b001, 4'h2, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 8'hE4, 8'h00, 4'h2, 1'b0, 1'b0));
    rows.push_back(mk(3'b001, 4'h2, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1, 8'h39, 8'h00, 4'h2, 1'b0, 1'b0));
    rows.push_back(mk(3'b101, 4'h2, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 8'hE4, 8'h00, 4'h0, 1'b0, 1'b0));
    rows.push_back(mk(3'b001, 4'h2, 4'h2, 4'h0, 4'h0, 4'hF, 1'b0, 8'hE4, 8'h04, 4'h0, 1'b0, 1'b1));
    rows.push_back(mk(3'b001, 4'h2, 4'h2, 4'h2, 4'h2, 4'hF, 1'b0, 8'hE4, 8'h04, 4'h0, 1'b0, 1'b1));
    rows.push_back(mk(3'b001, 4'h0, 4'h0, 4'h2, 4'h2, 4'hF, 1'b0, 8'hE4, 8'h00, 4'h0, 1'b0, 1'b0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sb.pop_front();
      n_total++;
      if (act !== e) $display("FAIL rst_boost_simul row %0d: got %h expected %h", i, act, e);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_outstanding();
    test_starve();
    test_multi_starve();
    test_enable_off();
    test_underflow();
    test_rst_boost_and_simul();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
